mod_updown_counter: RTL and testbench

- Parametrised synchronous counter family that succeeds the fixed 4-bit binary counter.
- Generalised to WIDTH bits, with a compile-time modulus and run-time up/down direction.
- Adds a synchronous clear, a cascade terminal-count output (TC) and a registered wrap pulse.
- Used as the counting element in the timing-circuit experiments: decade counters, frequency dividers and cascaded multi-digit counters.

---
 rtl/mod_updown_counter.sv | 115 +++++++++++
 tb/tb_mod_updown_counter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_updown_counter
//  Description : Parametrised synchronous modulo-N up/down counter with
//                synchronous clear, active-low parallel load, parallel and
//                trickle count enables, a combinational cascade terminal-count
//                output and a registered one-cycle wrap pulse.
//  Parameters  : WIDTH   - counter width in bits (1..16)
//                MODULUS - count length N, 2 <= N <= 2^WIDTH; sequence 0..N-1
//  Ports       : CP    in   clock, rising edge
//                MR    in   master reset, asynchronous, active-high
//                SCLR  in   synchronous clear, active-high
//                PE_N  in   parallel load enable, active-low, synchronous
//                CEP   in   count enable (parallel)
//                CET   in   count enable (trickle), also gates TC
//                UP    in   direction, 1 = up, 0 = down
//                D     in   parallel load data [WIDTH-1:0]
//                Q     out  registered count [WIDTH-1:0]
//                TC    out  terminal count (combinational)
//                WRAP  out  registered pulse, high the cycle after a terminal step
//  Options     : `define MOD_UPDOWN_COUNTER_SATURATE_EN makes a count step in
//                the terminal state hold Q instead of wrapping; WRAP still
//                pulses on every such attempted step.
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             CP,
    input  logic             MR,
    input  logic             SCLR,
    input  logic             PE_N,
    input  logic             CEP,
    input  logic             CET,
    input  logic             UP,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             WRAP
);

`ifdef MOD_UPDOWN_COUNTER_SATURATE_EN
    localparam bit C_SATURATE = 1'b1;
`else
    localparam bit C_SATURATE = 1'b0;
`endif

    // Largest legal count value (terminal state when counting up).
    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;

    logic             w_in_range;
    logic             w_terminal;
    logic             w_count_en;
    logic [WIDTH-1:0] w_next;

    // Loaded values above C_MAX are kept as-is; they only matter on the next
    // count step, which snaps them back into the legal sequence.
    assign w_in_range = (count_q <= C_MAX);
    assign w_terminal = UP ? (count_q == C_MAX) : (count_q == '0);
    assign w_count_en = CEP & CET;

    always_comb begin
        w_next = count_q;
        if (!w_in_range) begin
            w_next = UP ? '0 : C_MAX;
        end else if (w_terminal) begin
            if (C_SATURATE) begin
                w_next = count_q;
            end else begin
                w_next = UP ? '0 : C_MAX;
            end
        end else begin
            w_next = UP ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        end
    end

    // Priority: clear > load > count > hold. WRAP is only set by a count step
    // taken from the terminal state; an out-of-range snap is not a wrap, and
    // w_terminal already excludes out-of-range values.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (SCLR) begin
            count_d = '0;
        end else if (!PE_N) begin
            count_d = D;
        end else if (w_count_en) begin
            count_d = w_next;
            wrap_d  = w_terminal;
        end
    end

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign Q    = count_q;
    assign WRAP = wrap_q;
    // Independent of CEP so a cascade's upper stage sees TC without waiting.
    assign TC   = CET & w_terminal;

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_updown_counter
//  Description : Self-checking bench for mod_updown_counter (wrap build).
//                Directed sequences, a vector table, a two-digit cascade and
//                randomized traffic compared against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_updown_counter;

    logic       cp = 1'b0;
    logic       mr = 1'b1;
    logic       sclr = 1'b0;
    logic       pe_n = 1'b1;
    logic       cep = 1'b0;
    logic       cet = 1'b0;
    logic       up = 1'b1;
    logic [3:0] d = 4'd0;

    logic [3:0] q,   q16;
    logic       tc,  tc16;
    logic       wrap, wrap16;

    // cascade pair
    logic       cmr = 1'b1;
    logic       ccep = 1'b0;
    logic [3:0] q_lo, q_hi;
    logic       tc_lo, tc_hi, wrap_lo, wrap_hi;

    int n_pass  = 0;
    int n_total = 0;

    always #5 cp = ~cp;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .CP(cp), .MR(mr), .SCLR(sclr), .PE_N(pe_n), .CEP(cep), .CET(cet),
        .UP(up), .D(d), .Q(q), .TC(tc), .WRAP(wrap)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .CP(cp), .MR(mr), .SCLR(sclr), .PE_N(pe_n), .CEP(cep), .CET(cet),
        .UP(up), .D(d), .Q(q16), .TC(tc16), .WRAP(wrap16)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .CP(cp), .MR(cmr), .SCLR(1'b0), .PE_N(1'b1), .CEP(ccep), .CET(1'b1),
        .UP(1'b1), .D(4'd0), .Q(q_lo), .TC(tc_lo), .WRAP(wrap_lo)
    );

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .CP(cp), .MR(cmr), .SCLR(1'b0), .PE_N(1'b1), .CEP(ccep), .CET(tc_lo),
        .UP(1'b1), .D(4'd0), .Q(q_hi), .TC(tc_hi), .WRAP(wrap_hi)
    );

    typedef struct {
        logic       sclr;
        logic       pe_n;
        logic       cep;
        logic       cet;
        logic       up;
        logic [3:0] d;
        int         q;
        int         tc;
        int         wrap;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(input logic s, input logic p, input logic ce,
                                input logic ct, input logic u, input int dd,
                                input int eq, input int etc, input int ew);
        vec_t v;
        v.sclr = s; v.pe_n = p; v.cep = ce; v.cet = ct; v.up = u;
        v.d = 4'(dd); v.q = eq; v.tc = etc; v.wrap = ew;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    // Reference rules: modulo arithmetic on an integer count.
    function automatic void model_step(inout int mq, inout int mw, input int m,
                                       input logic s, input logic p, input logic ce,
                                       input logic ct, input logic u, input int dd);
        if (s) begin
            mq = 0; mw = 0;
        end else if (!p) begin
            mq = dd; mw = 0;
        end else if (ce && ct) begin
            if (mq >= m) begin
                mq = u ? 0 : m - 1;
                mw = 0;
            end else if (u) begin
                mw = (mq == m - 1) ? 1 : 0;
                mq = (mq + 1) % m;
            end else begin
                mw = (mq == 0) ? 1 : 0;
                mq = (mq + m - 1) % m;
            end
        end else begin
            mw = 0;
        end
    endfunction

    function automatic int model_tc(input int mq, input int m, input logic ct, input logic u);
        if (!ct) return 0;
        return (u ? (mq == m - 1) : (mq == 0)) ? 1 : 0;
    endfunction

    initial begin
        int eq;
        int mq[2];
        int mw[2];
        int mods[2];

        // ---------------- reset and release ----------------
        #1;
        chk("reset_q", int'(q), 0);
        chk("reset_wrap", int'(wrap), 0);
        step(); step();
        mr = 1'b0;
        pe_n = 1'b0; d = 4'd7;
        step();
        chk("load7_q", int'(q), 7);
        pe_n = 1'b1; cet = 1'b1; up = 1'b1; cep = 1'b0;
        #2 mr = 1'b1;
        #1;
        chk("async_mr_q", int'(q), 0);
        chk("async_mr_wrap", int'(wrap), 0);
        chk("async_mr_tc", int'(tc), 0);
        cep = 1'b1;
        step();
        chk("mr_held_no_count", int'(q), 0);
        mr = 1'b0;
        step();
        chk("first_count_after_release", int'(q), 1);

        // ---------------- up count, 12 edges from 0 ----------------
        sclr = 1'b1; step(); sclr = 1'b0;
        eq = 0;
        for (int i = 1; i <= 12; i++) begin
            chk("up_tc", int'(tc), (eq == 9) ? 1 : 0);
            step();
            eq = i % 10;
            chk("up_q", int'(q), eq);
            chk("up_wrap", int'(wrap), (i == 10) ? 1 : 0);
        end

        // ---------------- down count with direction change ----------------
        chk("down_start_q", int'(q), 2);
        up = 1'b0;
        step();
        chk("down_q1", int'(q), 1);
        chk("down_wrap1", int'(wrap), 0);
        step();
        chk("down_q0", int'(q), 0);
        chk("down_tc_at0", int'(tc), 1);
        step();
        chk("down_q9", int'(q), 9);
        chk("down_wrap_at9", int'(wrap), 1);
        chk("down_tc_at9", int'(tc), 0);
        up = 1'b1;
        #1;
        chk("dir_change_tc", int'(tc), 1);
        cep = 1'b0;
        step();
        chk("wrap_one_cycle", int'(wrap), 0);

        // ---------------- abort pending wrap with MR ----------------
        cep = 1'b1;
        step();
        chk("wrap_before_abort", int'(wrap), 1);
        #2 mr = 1'b1;
        #1;
        chk("abort_wrap", int'(wrap), 0);
        chk("abort_q", int'(q), 0);
        mr = 1'b0;

        // ---------------- vector table (starts from Q=0) ----------------
        //            sclr  pe_n  cep   cet   up   d   q  tc wrap
        vt[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  5,  5, 0, 0);
        vt[1]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1,  7,  0, 0, 0);
        vt[2]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12, 12, 0, 0);
        vt[3]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1,  0,  0, 0, 0);
        vt[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12, 12, 0, 0);
        vt[5]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  0,  9, 0, 0);
        vt[6]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  0,  8, 0, 0);
        vt[7]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  0,  8, 0, 0);
        vt[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0,  0,  8, 0, 0);
        vt[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1,  9,  9, 1, 0);
        vt[10] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b1,  0,  0, 0, 1);
        vt[11] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0,  0,  0, 1, 0);
        vt[12] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  0,  9, 0, 1);
        vt[13] = mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 15, 15, 0, 0);
        vt[14] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0,  0,  9, 0, 0);
        for (int i = 0; i < 15; i++) begin
            sclr = vt[i].sclr; pe_n = vt[i].pe_n; cep = vt[i].cep;
            cet = vt[i].cet; up = vt[i].up; d = vt[i].d;
            step();
            chk($sformatf("vec%0d_q", i), int'(q), vt[i].q);
            chk($sformatf("vec%0d_tc", i), int'(tc), vt[i].tc);
            chk($sformatf("vec%0d_wrap", i), int'(wrap), vt[i].wrap);
        end

        // ---------------- cascade: two decades ----------------
        cmr = 1'b0;
        ccep = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            chk("casc_tc_lo", int'(tc_lo), (((i - 1) % 10) == 9) ? 1 : 0);
            step();
            chk("casc_value", int'(q_hi) * 10 + int'(q_lo), i % 100);
        end
        chk("casc_hi_wrap", int'(wrap_hi), 1);
        ccep = 1'b0;
        step();
        chk("casc_hold", int'(q_hi) * 10 + int'(q_lo), 0);

        // ---------------- randomized vs model, MODULUS 10 and 16 ----------------
        sclr = 1'b0; pe_n = 1'b1; cep = 1'b0; cet = 1'b0;
        #2 mr = 1'b1;
        #1 mr = 1'b0;
        mods[0] = 10; mods[1] = 16;
        mq[0] = 0; mq[1] = 0; mw[0] = 0; mw[1] = 0;
        for (int i = 0; i < 400; i++) begin
            sclr = ($urandom_range(0, 19) == 0);
            pe_n = !($urandom_range(0, 9) == 0);
            cep  = ($urandom_range(0, 3) != 0);
            cet  = ($urandom_range(0, 3) != 0);
            up   = 1'($urandom_range(0, 1));
            d    = 4'($urandom_range(0, 15));
            #1;
            chk("rnd_tc10", int'(tc), model_tc(mq[0], mods[0], cet, up));
            chk("rnd_tc16", int'(tc16), model_tc(mq[1], mods[1], cet, up));
            step();
            for (int k = 0; k < 2; k++)
                model_step(mq[k], mw[k], mods[k], sclr, pe_n, cep, cet, up, int'(d));
            chk("rnd_q10", int'(q), mq[0]);
            chk("rnd_wrap10", int'(wrap), mw[0]);
            chk("rnd_q16", int'(q16), mq[1]);
            chk("rnd_wrap16", int'(wrap16), mw[1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
